// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter and its
// reusable add-3 digit cell.
package bin2bcd_pkg;

  localparam int WIDTH_DEF     = 16;
  localparam int DIGITS_DEF    = 5;
  localparam int RANGE_MAX_DEF = 9999;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  // Bit counter must hold the full iteration count, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake plus binary input and decimal digit outputs
// of the binary-to-BCD converter.
interface bin2bcd_seq_if
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] binary;
  logic             busy;
  logic             done;
  bcd_digit_t       ten_thousands;
  bcd_digit_t       thousands;
  bcd_digit_t       hundreds;
  bcd_digit_t       tens;
  bcd_digit_t       ones;
  logic             over_range;

  modport master (
    output start, binary,
    input  busy, done, ten_thousands, thousands, hundreds, tens, ones, over_range
  );

  modport slave (
    input  start, binary,
    output busy, done, ten_thousands, thousands, hundreds, tens, ones, over_range
  );

endinterface

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  // Conditional add-3; the result stays within the nibble.
  always_comb begin
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one shift-and-add-3 iteration per clock,
// results published with a one-cycle done pulse and held until the next one.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DIGITS    = DIGITS_DEF,
  parameter int RANGE_MAX = RANGE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int BCD_W = DIGITS * 4;
  localparam int SR_W  = BCD_W + WIDTH;

  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [WIDTH-1:0] RANGE_LIM = WIDTH'(RANGE_MAX);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic             ovr_flag_q, ovr_flag_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BCD_W-1:0] res_q, res_d;
  logic             over_range_q, over_range_d;

  logic [BCD_W-1:0] adj_s;
  logic [SR_W-1:0]  pre_shift_s;
  logic [SR_W-1:0]  shifted_s;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (sr_q[WIDTH + 4*g +: 4]),
      .dout (adj_s[4*g +: 4])
    );
  end

  assign pre_shift_s = {adj_s, sr_q[WIDTH-1:0]};
  assign shifted_s   = pre_shift_s << 1;

  // Next-state, iteration and result-publish logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    ovr_flag_d   = ovr_flag_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    res_d        = res_q;
    over_range_d = over_range_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = SHIFT;
          sr_d       = {{BCD_W{1'b0}}, bus.binary};
          cnt_d      = CNT_LOAD;
          busy_d     = 1'b1;
          ovr_flag_d = (bus.binary > RANGE_LIM);
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        sr_d  = shifted_s;
        cnt_d = cnt_q - CNT_ONE;
        // The last iteration publishes straight from the freshly shifted value.
        if (cnt_q == CNT_ONE) begin
          state_d      = IDLE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          res_d        = shifted_s[SR_W-1 -: BCD_W];
          over_range_d = ovr_flag_q;
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sr_q         <= '0;
      ovr_flag_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      res_q        <= '0;
      over_range_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      ovr_flag_q   <= ovr_flag_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      res_q        <= res_d;
      over_range_q <= over_range_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.over_range    = over_range_q;
  assign bus.ten_thousands = res_q[16 +: 4];
  assign bus.thousands     = res_q[12 +: 4];
  assign bus.hundreds      = res_q[8 +: 4];
  assign bus.tens          = res_q[4 +: 4];
  assign bus.ones          = res_q[0 +: 4];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and randomized checks of bin2bcd_seq against a decimal
// divide/modulo reference model.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bin2bcd_seq_if #(.WIDTH(16)) bus ();

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .RANGE_MAX(9999)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $error("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int x;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [19:0] dut_digits();
    return {bus.ten_thousands, bus.thousands, bus.hundreds, bus.tens, bus.ones};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive start for one edge; returns at the negedge after the accepting edge.
  task automatic start_conv(input int v);
    @(negedge clk);
    bus.binary = 16'(v);
    bus.start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  // Count cycles from the accepting edge until done, with a bounded wait.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end else begin
        busy_cnt += (bus.busy === 1'b1) ? 1 : 0;
      end
    end
  endtask

  task automatic run_full(input string tag, input int v);
    int lat, bc;
    start_conv(v);
    wait_done(lat, bc);
    check({tag, "_latency"}, lat, 32'd16);
    check({tag, "_busy_cycles"}, bc, 32'd16);
    check({tag, "_busy_at_done"}, bus.busy, 32'd0);
    check({tag, "_digits"}, dut_digits(), ref_bcd(v));
    check({tag, "_over_range"}, bus.over_range, (v > 9999) ? 32'd1 : 32'd0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, bus.done, 32'd0);
  endtask

  initial begin
    int lat, bc, lat1, ndone, v;
    logic [19:0] held;

    bus.start  = 1'b0;
    bus.binary = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", bus.busy, 32'd0);
    check("reset_done", bus.done, 32'd0);
    check("reset_digits", dut_digits(), 32'd0);
    check("reset_over_range", bus.over_range, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_full("zero", 0);
    run_full("d1234", 1234);

    // 9999 then 10000 with the second start held during the done cycle
    start_conv(9999);
    wait_done(lat1, bc);
    check("b2b_first_latency", lat1, 32'd16);
    check("b2b_first_digits", dut_digits(), ref_bcd(9999));
    check("b2b_first_over", bus.over_range, 32'd0);
    bus.binary = 16'd10000;
    bus.start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b0;
    check("b2b_second_accepted", bus.busy, 32'd1);
    check("b2b_done_cleared", bus.done, 32'd0);
    wait_done(lat, bc);
    check("b2b_second_total", lat1 + 1 + lat, 32'd33);
    check("b2b_second_digits", dut_digits(), ref_bcd(10000));
    check("b2b_second_over", bus.over_range, 32'd1);
    @(negedge clk);

    run_full("max", 65535);
    repeat (5) @(negedge clk);
    check("hold_idle_digits", dut_digits(), ref_bcd(65535));

    // 4321 with an ignored start mid-conversion; old result must stay visible
    start_conv(4321);
    ndone = 0;
    lat   = 0;
    held  = '0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 4) begin
        bus.binary = 16'd777;
        bus.start  = 1'b1;
      end else if (k == 5) begin
        bus.start  = 1'b0;
      end
      if (k == 8) begin
        check("hold_busy_digits", dut_digits(), ref_bcd(65535));
        check("hold_busy_over", bus.over_range, 32'd1);
      end
      if (bus.done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          lat  = k;
          held = dut_digits();
        end
      end
    end
    check("ignore_done_count", ndone, 32'd1);
    check("ignore_latency", lat, 32'd16);
    check("ignore_digits", held, ref_bcd(4321));
    check("ignore_idle_busy", bus.busy, 32'd0);

    // asynchronous reset mid-conversion
    start_conv(5000);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", bus.busy, 32'd0);
    check("arst_done", bus.done, 32'd0);
    check("arst_digits", dut_digits(), 32'd0);
    check("arst_over", bus.over_range, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ndone += (bus.done === 1'b1) ? 1 : 0;
    end
    check("arst_no_done", ndone, 32'd0);
    check("arst_digits_after", dut_digits(), 32'd0);
    run_full("after_reset_42", 42);

    for (int n = 0; n < 12; n++) begin
      v = int'($urandom_range(0, 65535));
      run_full($sformatf("rand%0d_%0d", n, v), v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
